handshake_rr_arbiter: RTL and testbench
=======================================

// Module: handshake_rr_arbiter
// PURPOSE
//  Round-robin arbiter that shares one downstream handshake channel (e.g. a shared
//  constant/operator unit) between NUM_INPUTS valid/ready requesters.
//  Selects one pending token per cycle, registers it in a one-slot output buffer
//  and emits it with the index of the winning input.
//  Sits between producer handshake units and a shared consumer in the dataflow fabric.
// PARAMETERS
//  NUM_INPUTS   4   number of requester channels (>=2, need not be a power of 2)
//  DATA_WIDTH   32  token width
//  INDEX_WIDTH  2   width of index output; must be >= clog2(NUM_INPUTS)
// PORTS
//  clk         in   1                      clock, rising edge
//  rst         in   1                      asynchronous, active-low reset
//  ins         in   NUM_INPUTS*DATA_WIDTH  input tokens; input i is ins[i*DATA_WIDTH +: DATA_WIDTH]
//  ins_valid   in   NUM_INPUTS             per-input valid
//  ins_ready   out  NUM_INPUTS             per-input ready
//  outs        out  DATA_WIDTH             granted token
//  index       out  INDEX_WIDTH            input number that produced outs
//  outs_valid  out  1                      outs/index valid
//  outs_ready  in   1                      downstream ready
// BEHAVIOUR
//  State: ptr (round-robin pointer, 0..NUM_INPUTS-1), full (slot occupied), data_q, index_q.
//  Reset (rst=0, async): ptr=0, full=0, outs_valid=0, outs=0, index=0, ins_ready=0.
//  Grant (combinational): g = first i with ins_valid[i]=1, scanning ptr, ptr+1, ...
//   wrapping modulo NUM_INPUTS; any_valid = |ins_valid.
//  can_load = !full || outs_ready (slot free or draining this cycle).
//  ins_ready[i] = can_load && any_valid && (i == g); at most one bit set. No other
//   input is ready in that cycle, even if valid.
//  Accept (ins_valid[g] && ins_ready[g]): data_q <= ins[g], index_q <= g, full <= 1,
//   ptr <= (g == NUM_INPUTS-1) ? 0 : g+1.
//  Drain only (outs_valid && outs_ready, no accept): full <= 0; data_q/index_q hold.
//  Simultaneous drain and accept: full stays 1; new token replaces old.
//   Full throughput: 1 token/cycle.
//  Stall (full && !outs_ready): all ins_ready=0; outs, index and ptr hold.
//  outs=data_q, index=index_q, outs_valid=full (registered; no comb path ins->outs).
//  Latency: token accepted at edge N is on outs with outs_valid=1 after edge N.
//  ptr advances only on accept. Idle cycles and stalls never move it.
//  Fairness: any valid input is granted within NUM_INPUTS accepts.
//  Wrap-around: ptr N-1 -> 0. Non-power-of-2 N never yields ptr/index >= N.
//  Reset mid-operation: buffered token is discarded; outs_valid drops immediately (async).
//  Inputs must hold valid/data until ready. Arbiter does not check this.
// TESTING
//  1 Reset with all ins_valid=1 -> outs_valid=0, ins_ready=0000; first accept after
//    release grants input 0.
//  2 N=4, all valid, outs_ready=1, ins[i]=0x10+i -> outs 0x10,0x11,0x12,0x13,0x10
//    on consecutive cycles; index 0,1,2,3,0.
//  3 Only input 2 valid (0xAB), then inputs 0 and 2 valid -> grants 2, then 0 (ptr=3
//    wraps), then 2.
//  4 outs_ready=0 for 5 cycles with token 0x55 held -> outs=0x55 and index stable;
//    ins_ready=0; ptr unchanged; on release, drain and new accept in the same cycle.
//  5 Assert rst while full=1 and outs_ready=0 -> outs_valid=0 asynchronously; after
//    release, ptr=0 and no stale token appears.
//  6 NUM_INPUTS=3, INDEX_WIDTH=2, all valid -> index sequence 0,1,2,0; never 3.

Source files
------------

// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter
//   Shares one downstream valid/ready channel between NUM_INPUTS requesters.
//   A round-robin pointer picks the first valid input at or after it. The
//   winning token is captured in a one-slot output register and tagged with
//   the number of the input that supplied it. Outputs come straight from
//   flops, so there is no combinational path from the inputs to outs.
//   The slot refills in the same cycle it drains, which gives one token per
//   cycle at full throughput.

module handshake_rr_arbiter #(
   parameter int NUM_INPUTS  = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] ins,
   input  logic [NUM_INPUTS-1:0]            ins_valid,
   output logic [NUM_INPUTS-1:0]            ins_ready,
   output logic [DATA_WIDTH-1:0]            outs,
   output logic [INDEX_WIDTH-1:0]           index,
   output logic                             outs_valid,
   input  logic                             outs_ready
);

   localparam int unsigned N_U = unsigned'(NUM_INPUTS);

   // The index output must be able to name every input. A round-robin
   // arbiter with a single requester has nothing to arbitrate.
   if (NUM_INPUTS < 2) begin : g_bad_num_inputs
      $error("handshake_rr_arbiter: NUM_INPUTS must be at least 2");
   end
   if (INDEX_WIDTH < $clog2(NUM_INPUTS)) begin : g_bad_index_width
      $error("handshake_rr_arbiter: INDEX_WIDTH too narrow for NUM_INPUTS");
   end

   // Returns (base + step) modulo NUM_INPUTS. Both operands are already
   // below NUM_INPUTS, so one conditional subtraction is enough, and the
   // result stays correct when NUM_INPUTS is not a power of two.
   function automatic int unsigned rr_offset(input int unsigned base,
                                             input int unsigned step);
      int unsigned sum_v;
      sum_v = base + step;
      if (sum_v >= N_U) begin
         sum_v = sum_v - N_U;
      end else begin
         sum_v = sum_v;
      end
      return sum_v;
   endfunction

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [INDEX_WIDTH-1:0] ptr_q,   ptr_d;
   logic                   full_q,  full_d;
   logic [DATA_WIDTH-1:0]  data_q,  data_d;
   logic [INDEX_WIDTH-1:0] index_q, index_d;

   // ------------------------------------------------------------------
   // Combinational arbitration
   // ------------------------------------------------------------------
   logic [INDEX_WIDTH-1:0] grant_s;
   logic                   found_s;
   logic                   any_valid_s;
   logic                   can_load_s;
   logic                   accept_s;
   logic [DATA_WIDTH-1:0]  grant_data_s;

   assign any_valid_s = |ins_valid;

   // The slot can take a token when it is empty or is being drained now.
   assign can_load_s  = !full_q || outs_ready;

   // An accept always targets the granted input, which is valid by construction.
   assign accept_s    = can_load_s && any_valid_s && found_s;

   // Round-robin scan: the first valid input at ptr, ptr+1, ... with wrap-around.
   always_comb begin
      grant_s = '0;
      found_s = 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!found_s && ins_valid[i] &&
                (rr_offset(32'(ptr_q), unsigned'(k)) == unsigned'(i))) begin
               grant_s = INDEX_WIDTH'(i);
               found_s = 1'b1;
            end else begin
               found_s = found_s;
            end
         end
      end
   end

   // Select the winning input's token for loading into the slot.
   always_comb begin
      grant_data_s = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (grant_s == INDEX_WIDTH'(i)) begin
            grant_data_s = ins[i*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            grant_data_s = grant_data_s;
         end
      end
   end

   // Only the granted input sees ready. It is forced low while reset is held,
   // so nothing looks accepted during reset.
   always_comb begin
      ins_ready = '0;
      for (int i = 0; i < NUM_INPUTS; i++) begin
         if (rst && accept_s && (grant_s == INDEX_WIDTH'(i))) begin
            ins_ready[i] = 1'b1;
         end else begin
            ins_ready[i] = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state
   // ------------------------------------------------------------------
   // An accept refills the slot and moves the pointer past the winner.
   // A drain on its own empties the slot and leaves data and index as they were.
   // A stall or an idle cycle leaves everything untouched.
   always_comb begin
      ptr_d   = ptr_q;
      full_d  = full_q;
      data_d  = data_q;
      index_d = index_q;
      if (accept_s) begin
         data_d  = grant_data_s;
         index_d = grant_s;
         full_d  = 1'b1;
         ptr_d   = INDEX_WIDTH'(rr_offset(32'(grant_s), 32'd1));
      end else if (full_q && outs_ready) begin
         full_d  = 1'b0;
      end else begin
         full_d  = full_q;
      end
   end

   // State register. Reset throws away any buffered token at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_q   <= '0;
         full_q  <= 1'b0;
         data_q  <= '0;
         index_q <= '0;
      end else begin
         ptr_q   <= ptr_d;
         full_q  <= full_d;
         data_q  <= data_d;
         index_q <= index_d;
      end
   end

   // ------------------------------------------------------------------
   // Registered outputs
   // ------------------------------------------------------------------
   assign outs       = data_q;
   assign index      = index_q;
   assign outs_valid = full_q;

endmodule

// handshake_rr_arbiter_chk
//   Protocol properties of the arbiter ports. Nothing is checked while reset
//   is held.
module handshake_rr_arbiter_chk #(
   parameter int NUM_INPUTS  = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int INDEX_WIDTH = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_INPUTS-1:0]  ins_ready,
   input  logic [DATA_WIDTH-1:0]  outs,
   input  logic [INDEX_WIDTH-1:0] index,
   input  logic                   outs_valid,
   input  logic                   outs_ready
);

   logic                   stall_q;
   logic [DATA_WIDTH-1:0]  outs_q;
   logic [INDEX_WIDTH-1:0] index_q;

   // Remember the previous cycle's output and whether it was stalled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q <= 1'b0;
         outs_q  <= '0;
         index_q <= '0;
      end else begin
         stall_q <= outs_valid && !outs_ready;
         outs_q  <= outs;
         index_q <= index;
      end
   end

   // Per-edge properties: one ready at most, no ready while stalled,
   // index always in range, and a stalled output holds.
   always @(posedge clk) begin
      if (rst) begin
         assert ($onehot0(ins_ready))
            else $error("arbiter: more than one ins_ready set");
         if (outs_valid && !outs_ready) begin
            assert (ins_ready == '0)
               else $error("arbiter: ins_ready raised while stalled");
         end
         if (outs_valid) begin
            assert (32'(index) < unsigned'(NUM_INPUTS))
               else $error("arbiter: index out of range");
         end
         if (stall_q) begin
            assert (outs_valid && (outs == outs_q) && (index == index_q))
               else $error("arbiter: stalled output changed");
         end
      end
   end

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// tb_handshake_rr_arbiter
//   Directed stimulus for a 4-input arbiter, plus a 3-input arbiter that runs
//   with every input valid. On each falling edge a behavioural model checks
//   every output. Literal expectations in the stimulus pin down the model.
module tb_handshake_rr_arbiter;

   logic             clk = 1'b0;
   logic             rst;

   logic [3:0][31:0] ins_p;
   logic [3:0]       ins_valid;
   logic [3:0]       ins_ready;
   logic [31:0]      outs;
   logic [1:0]       index;
   logic             outs_valid;
   logic             outs_ready;

   logic [2:0][31:0] ins3_p;
   logic [2:0]       ins3_valid;
   logic [2:0]       ins3_ready;
   logic [31:0]      outs3;
   logic [1:0]       index3;
   logic             outs3_valid;
   logic             outs3_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   handshake_rr_arbiter #(.NUM_INPUTS(4), .DATA_WIDTH(32), .INDEX_WIDTH(2)) dut (
      .clk(clk), .rst(rst), .ins(ins_p), .ins_valid(ins_valid), .ins_ready(ins_ready),
      .outs(outs), .index(index), .outs_valid(outs_valid), .outs_ready(outs_ready));

   handshake_rr_arbiter_chk #(.NUM_INPUTS(4), .DATA_WIDTH(32), .INDEX_WIDTH(2)) chk4 (
      .clk(clk), .rst(rst), .ins_ready(ins_ready), .outs(outs), .index(index),
      .outs_valid(outs_valid), .outs_ready(outs_ready));

   handshake_rr_arbiter #(.NUM_INPUTS(3), .DATA_WIDTH(32), .INDEX_WIDTH(2)) dut3 (
      .clk(clk), .rst(rst), .ins(ins3_p), .ins_valid(ins3_valid), .ins_ready(ins3_ready),
      .outs(outs3), .index(index3), .outs_valid(outs3_valid), .outs_ready(outs3_ready));

   handshake_rr_arbiter_chk #(.NUM_INPUTS(3), .DATA_WIDTH(32), .INDEX_WIDTH(2)) chk3 (
      .clk(clk), .rst(rst), .ins_ready(ins3_ready), .outs(outs3), .index(index3),
      .outs_valid(outs3_valid), .outs_ready(outs3_ready));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model, evaluated on each falling edge. The inputs are stable
   // from 1 ns after a rising edge until the next rising edge. So the model
   // first checks the current outputs, then predicts what the coming edge
   // will do.
   int          m_ptr;
   bit          m_full;
   logic [31:0] m_data;
   int          m_idx;
   int          cnt3;
   int          g;
   int          c;
   int          e3;
   bit          can_load;
   logic [3:0]  exp_rdy;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst) begin
            m_ptr = 0; m_full = 1'b0; m_data = 32'h0; m_idx = 0; cnt3 = 0;
            chk("m_rst_outs_valid", 64'(outs_valid), 64'd0);
            chk("m_rst_outs", 64'(outs), 64'd0);
            chk("m_rst_index", 64'(index), 64'd0);
            chk("m_rst_ins_ready", 64'(ins_ready), 64'd0);
            chk("m_rst_outs3_valid", 64'(outs3_valid), 64'd0);
            chk("m_rst_ins3_ready", 64'(ins3_ready), 64'd0);
         end else begin
            // 4-input arbiter: grant is the first valid input from the pointer, modulo 4
            g = -1;
            for (int k = 0; k < 4; k++) begin
               c = (m_ptr + k) % 4;
               if (g < 0 && ins_valid[c[1:0]]) g = c;
            end
            can_load = !m_full || outs_ready;
            exp_rdy = 4'b0000;
            if (can_load && g >= 0) exp_rdy = 4'b0001 << g;
            chk("m_outs_valid", 64'(outs_valid), 64'(m_full));
            chk("m_outs", 64'(outs), 64'(m_data));
            chk("m_index", 64'(index), 64'(m_idx));
            chk("m_ins_ready", 64'(ins_ready), 64'(exp_rdy));
            if (can_load && g >= 0) begin
               m_data = ins_p[g[1:0]];
               m_idx  = g;
               m_full = 1'b1;
               m_ptr  = (g + 1) % 4;
            end else if (m_full && outs_ready) begin
               m_full = 1'b0;
            end

            // 3-input arbiter, always all valid and ready: accept n gets index n mod 3
            if (cnt3 == 0) begin
               chk("m3_outs_valid", 64'(outs3_valid), 64'd0);
            end else begin
               e3 = (cnt3 - 1) % 3;
               chk("m3_outs_valid", 64'(outs3_valid), 64'd1);
               chk("m3_index", 64'(index3), 64'(e3));
               chk("m3_outs", 64'(outs3), 64'(32'h30 + e3));
            end
            chk("m3_ins_ready", 64'(ins3_ready), 64'(3'b001 << (cnt3 % 3)));
            cnt3++;
         end
      end
   end

   // Directed stimulus with hand-computed expectations
   initial begin
      rst        = 1'b0;
      outs_ready = 1'b1;
      ins_valid  = 4'b1111;
      for (int i = 0; i < 4; i++) ins_p[i] = 32'h10 + 32'(i);
      for (int i = 0; i < 3; i++) ins3_p[i] = 32'h30 + 32'(i);
      ins3_valid  = 3'b111;
      outs3_ready = 1'b1;

      // 1: held in reset with every input valid
      step();
      step();
      chk("t1_rst_outs_valid", 64'(outs_valid), 64'd0);
      chk("t1_rst_ins_ready", 64'(ins_ready), 64'd0);
      rst = 1'b1;
      #1;
      chk("t1_first_ready", 64'(ins_ready), 64'h1);
      chk("t1_first_ready3", 64'(ins3_ready), 64'h1);

      // 2: full-rate rotation 0,1,2,3,0 (and 0,1,2,0,1 on the 3-input instance)
      for (int j = 0; j < 5; j++) begin
         step();
         chk("t2_outs", 64'(outs), 64'(32'h10 + 32'(j % 4)));
         chk("t2_index", 64'(index), 64'(j % 4));
         chk("t2_outs_valid", 64'(outs_valid), 64'd1);
         chk("t6_index3", 64'(index3), 64'(j % 3));
      end

      // 3: pointer is now 1. Input 2 alone, then inputs 0 and 2 -> 2, 0, 2
      ins_valid = 4'b0100;
      ins_p[2]  = 32'hAB;
      step();
      chk("t3_outs_a", 64'(outs), 64'hAB);
      chk("t3_index_a", 64'(index), 64'd2);
      ins_valid = 4'b0101;
      ins_p[0]  = 32'hC0;
      step();
      chk("t3_outs_b", 64'(outs), 64'hC0);
      chk("t3_index_b", 64'(index), 64'd0);
      step();
      chk("t3_outs_c", 64'(outs), 64'hAB);
      chk("t3_index_c", 64'(index), 64'd2);

      // 4: drain, load 0x55 from input 3 (pointer -> 0), then stall for 5 cycles
      ins_valid = 4'b0000;
      step();
      chk("t4_drained", 64'(outs_valid), 64'd0);
      ins_valid = 4'b1000;
      ins_p[3]  = 32'h55;
      step();
      chk("t4_load_outs", 64'(outs), 64'h55);
      chk("t4_load_index", 64'(index), 64'd3);
      outs_ready = 1'b0;
      ins_valid  = 4'b0110;
      ins_p[1]   = 32'h66;
      ins_p[2]   = 32'h77;
      for (int j = 0; j < 5; j++) begin
         step();
         chk("t4_stall_outs", 64'(outs), 64'h55);
         chk("t4_stall_index", 64'(index), 64'd3);
         chk("t4_stall_valid", 64'(outs_valid), 64'd1);
         chk("t4_stall_ready", 64'(ins_ready), 64'd0);
      end
      outs_ready = 1'b1;
      #1;
      chk("t4_release_ready", 64'(ins_ready), 64'h2);
      step();
      chk("t4_swap_outs", 64'(outs), 64'h66);
      chk("t4_swap_index", 64'(index), 64'd1);
      chk("t4_swap_valid", 64'(outs_valid), 64'd1);

      // 5: asynchronous reset while the slot is full and stalled
      outs_ready = 1'b0;
      ins_valid  = 4'b0000;
      step();
      #2;
      rst = 1'b0;
      #1;
      chk("t5_async_valid", 64'(outs_valid), 64'd0);
      chk("t5_async_outs", 64'(outs), 64'd0);
      chk("t5_async_index", 64'(index), 64'd0);
      chk("t5_async_ready", 64'(ins_ready), 64'd0);
      step();
      rst        = 1'b1;
      ins_valid  = 4'b1111;
      for (int i = 0; i < 4; i++) ins_p[i] = 32'h20 + 32'(i);
      outs_ready = 1'b1;
      #1;
      chk("t5_no_stale", 64'(outs_valid), 64'd0);
      chk("t5_ptr_zero", 64'(ins_ready), 64'h1);
      step();
      chk("t5_after_outs", 64'(outs), 64'h20);
      chk("t5_after_index", 64'(index), 64'd0);
      step();
      chk("t5_next_outs", 64'(outs), 64'h21);
      chk("t5_next_index", 64'(index), 64'd1);

      // let the 3-input instance wrap a few more times under the model
      ins_valid = 4'b0000;
      for (int j = 0; j < 6; j++) step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
